// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with registered
// blanking, syncs, start pulses, frame number and a position that leads blanking.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LEAD     = 2,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          blanking,
  output logic          h_sync,
  output logic          v_sync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [XW-1:0] hc, lx;
  logic [YW-1:0] vc, ly;
  logic [7:0]    fc;
  logic          h_wrap, v_wrap, lx_wrap, ly_wrap;
  logic          in_active, in_hs, in_vs;

  always_comb begin
    h_wrap    = (int'(hc) == H_TOTAL - 1);
    v_wrap    = (int'(vc) == V_TOTAL - 1);
    lx_wrap   = (int'(lx) == H_TOTAL - 1);
    ly_wrap   = (int'(ly) == V_TOTAL - 1);
    in_active = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
    in_hs     = (int'(hc) >= HS_START) && (int'(hc) < HS_END);
    in_vs     = (int'(vc) >= VS_START) && (int'(vc) < VS_END);
  end

  // (lx,ly) is a second raster counter started LEAD pixels ahead of (hc,vc),
  // so the lead position never needs a multiply or a modulo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      lx          <= XW'(LEAD);
      ly          <= '0;
      fc          <= '0;
      x           <= '0;
      y           <= '0;
      blanking    <= 1'b1;
      h_sync      <= !HS_POL;
      v_sync      <= !VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (enable) begin
      x           <= lx;
      y           <= ly;
      blanking    <= !in_active;
      h_sync      <= in_hs ? HS_POL : !HS_POL;
      v_sync      <= in_vs ? VS_POL : !VS_POL;
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
      frame_cnt   <= fc;
      hc <= h_wrap ? '0 : hc + 1'b1;
      if (h_wrap) begin
        vc <= v_wrap ? '0 : vc + 1'b1;
        if (v_wrap) fc <= fc + 1'b1;
      end
      lx <= lx_wrap ? '0 : lx + 1'b1;
      if (lx_wrap) ly <= ly_wrap ? '0 : ly + 1'b1;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a default-size instance for the 640x480 line timing and a
// 16x8-total instance for frame, lead-wrap, enable-hold and frame_cnt wrap.
module tb_video_timing_gen;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
  int checks = 0, errors = 0;

  // small: H 8+2+3+3=16, V 4+1+2+1=8, hsync hc 10..12 low, vsync vc 5..6 high
  logic [3:0] s_x;  logic [2:0] s_y;  logic [7:0] s_fc;
  logic s_bl, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] d_x, d_y;  logic [7:0] d_fc;
  logic d_bl, d_hs, d_vs, d_ls, d_fs;

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1),
    .LEAD(2), .XW(4), .YW(3)) u_s (
    .clk(clk), .rst(rst), .enable(enable), .x(s_x), .y(s_y), .blanking(s_bl),
    .h_sync(s_hs), .v_sync(s_vs), .line_start(s_ls), .frame_start(s_fs),
    .frame_cnt(s_fc));

  video_timing_gen u_d (
    .clk(clk), .rst(rst), .enable(enable), .x(d_x), .y(d_y), .blanking(d_bl),
    .h_sync(d_hs), .v_sync(d_vs), .line_start(d_ls), .frame_start(d_fs),
    .frame_cnt(d_fc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " s_x"}, int'(s_x), 0);     chk({tag, " s_y"}, int'(s_y), 0);
    chk({tag, " s_bl"}, int'(s_bl), 1);   chk({tag, " s_hs"}, int'(s_hs), 1);
    chk({tag, " s_vs"}, int'(s_vs), 0);   chk({tag, " s_ls"}, int'(s_ls), 0);
    chk({tag, " s_fs"}, int'(s_fs), 0);   chk({tag, " s_fc"}, int'(s_fc), 0);
    chk({tag, " d_bl"}, int'(d_bl), 1);   chk({tag, " d_hs"}, int'(d_hs), 1);
    chk({tag, " d_vs"}, int'(d_vs), 1);   chk({tag, " d_x"}, int'(d_x), 0);
  endtask

  task automatic chk_first(input string tag);
    chk({tag, " s_x"}, int'(s_x), 2);     chk({tag, " s_y"}, int'(s_y), 0);
    chk({tag, " s_bl"}, int'(s_bl), 0);   chk({tag, " s_hs"}, int'(s_hs), 1);
    chk({tag, " s_vs"}, int'(s_vs), 0);   chk({tag, " s_ls"}, int'(s_ls), 1);
    chk({tag, " s_fs"}, int'(s_fs), 1);   chk({tag, " s_fc"}, int'(s_fc), 0);
    chk({tag, " d_x"}, int'(d_x), 2);     chk({tag, " d_y"}, int'(d_y), 0);
    chk({tag, " d_bl"}, int'(d_bl), 0);   chk({tag, " d_hs"}, int'(d_hs), 1);
    chk({tag, " d_vs"}, int'(d_vs), 1);   chk({tag, " d_ls"}, int'(d_ls), 1);
    chk({tag, " d_fs"}, int'(d_fs), 1);   chk({tag, " d_fc"}, int'(d_fc), 0);
  endtask

  initial begin
    int hs_low, hs_first, bl_rise, ls_cnt, ls_pos;
    int vs_cnt, vs_first, bl_cnt, fs_cnt, n, cyc, last, exp_fc, fs_seen, bad;

    // reset asserted before any clock edge
    #1 rst = 1'b1;
    #1 chk_reset("reset");
    tick(); tick();
    @(negedge clk); rst = 1'b0; enable = 1'b1;
    tick();
    chk_first("first");

    // one default line: blanking at 640, hsync low 656..751, next line at 800
    hs_low = 0; hs_first = -1; bl_rise = -1; ls_cnt = 0; ls_pos = -1;
    for (int p = 1; p <= 800; p++) begin
      tick();
      if (!d_hs) begin hs_low++; if (hs_first < 0) hs_first = p; end
      if (d_bl && bl_rise < 0) bl_rise = p;
      if (d_ls) begin ls_cnt++; ls_pos = p; end
      if (p == 798) begin
        chk("d_x hc798", int'(d_x), 0); chk("d_y hc798", int'(d_y), 1);
      end
      if (p == 799) begin
        chk("d_x hc799", int'(d_x), 1); chk("d_y hc799", int'(d_y), 1);
      end
    end
    chk("d blank rise", bl_rise, 640);
    chk("d hsync low", hs_low, 96);
    chk("d hsync first", hs_first, 656);
    chk("d line_start count", ls_cnt, 1);
    chk("d line_start period", ls_pos, 800);

    // async reset between edges, mid-frame
    #2 rst = 1'b1;
    #1 chk_reset("async reset");
    #2 rst = 1'b0;
    tick();
    chk_first("after reset");

    // one small frame, positions 1..127, then the next frame start
    vs_cnt = 0; vs_first = -1; bl_cnt = 0; ls_cnt = 0; fs_cnt = 0; hs_low = 0;
    for (int p = 1; p <= 127; p++) begin
      tick();
      if (s_vs) begin vs_cnt++; if (vs_first < 0) vs_first = p; end
      if (s_bl) bl_cnt++;
      if (s_ls) ls_cnt++;
      if (s_fs) fs_cnt++;
      if (!s_hs) hs_low++;
      if (p == 15) begin
        chk("s_x hc15 vc0", int'(s_x), 1); chk("s_y hc15 vc0", int'(s_y), 1);
      end
      if (p == 126) begin
        chk("s_x hc14 vc7", int'(s_x), 0); chk("s_y hc14 vc7", int'(s_y), 0);
      end
      if (p == 127) begin
        chk("s_x hc15 vc7", int'(s_x), 1); chk("s_y hc15 vc7", int'(s_y), 0);
      end
    end
    chk("s vsync count", vs_cnt, 32);
    chk("s vsync first", vs_first, 80);
    chk("s blank count", bl_cnt, 96);
    chk("s line_start count", ls_cnt, 7);
    chk("s frame_start count", fs_cnt, 0);
    chk("s hsync low", hs_low, 24);
    tick();
    chk("s fs frame1", int'(s_fs), 1);
    chk("s fc frame1", int'(s_fc), 1);
    chk("s x frame1", int'(s_x), 2);

    // hold for 10 clocks: outputs frozen, pulses cleared
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold ls", int'(s_ls), 0);  chk("hold fs", int'(s_fs), 0);
      chk("hold x", int'(s_x), 2);    chk("hold bl", int'(s_bl), 0);
      chk("hold fc", int'(s_fc), 1);  chk("hold hs", int'(s_hs), 1);
    end
    enable = 1'b1;
    tick();
    chk("resume x", int'(s_x), 3);
    chk("resume ls", int'(s_ls), 0);
    n = 1;
    while (!s_ls && n < 100) begin tick(); n++; end
    chk("held line length", 10 + n, 26);

    // frame_cnt 2..255 then wrap to 0, frame period 128
    cyc = 0; last = -1; exp_fc = 2; fs_seen = 0; bad = 0;
    while (fs_seen < 255 && cyc < 40000) begin
      tick(); cyc++;
      if (s_fs) begin
        if (int'(s_fc) != exp_fc) bad++;
        if (last >= 0 && cyc - last != 128) bad++;
        last = cyc; exp_fc = (exp_fc + 1) % 256; fs_seen++;
      end
    end
    chk("frame starts seen", fs_seen, 255);
    chk("frame_cnt/period errors", bad, 0);
    chk("frame_cnt wrapped", int'(s_fc), 0);

    // reset while disabled
    enable = 1'b0;
    #3 rst = 1'b1;
    #1 chk("rst dis s_x", int'(s_x), 0);
    chk("rst dis s_bl", int'(s_bl), 1);
    chk("rst dis s_fc", int'(s_fc), 0);
    #2 rst = 1'b0; enable = 1'b1;
    tick();
    chk_first("reenable");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE 640: visible pixels per line
- H_FP 16: horizontal front porch
- H_SYNC 96: hsync width
- H_BP 48: horizontal back porch
- V_ACTIVE 480: visible lines
- V_FP 10: vertical front porch
- V_SYNC 2: vsync width
- V_BP 33: vertical back porch
- HS_POL 0: hsync active level
- VS_POL 0: vsync active level
- LEAD 2: cycles by which x/y lead blanking
- XW 10: x width
- YW 10: y width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk: in, 1, pixel clock; the single clock
- rst: in, 1, asynchronous, active-high reset
- enable: in, 1, advance timing when high
- x: out, XW, lead horizontal position
- y: out, YW, lead vertical position
- blanking: out, 1, high outside the active area
- h_sync: out, 1
- v_sync: out, 1
- line_start: out, 1, pulse at position hc=0
- frame_start: out, 1, pulse at position (0,0)
- frame_cnt: out, 8, frame number

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL be derived constants; legal parameters require H_TOTAL <= 2^XW, V_TOTAL <= 2^YW, and 0 <= LEAD < H_TOTAL.
REQ-004 Internal counter hc SHALL count 0..H_TOTAL-1 and wrap to 0; vc SHALL increment only on hc wrap, count 0..V_TOTAL-1, and wrap to 0.
REQ-005 On each clk edge with enable=1, all outputs SHALL be registered from the current (hc,vc), and the counters SHALL then advance, giving an output latency of 1 cycle.
REQ-006 blanking SHALL be 0 iff hc < H_ACTIVE and vc < V_ACTIVE.
REQ-007 h_sync SHALL equal HS_POL for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] and !HS_POL otherwise, independent of vc.
REQ-008 v_sync SHALL equal VS_POL for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] and !VS_POL otherwise; it changes only together with an hc wrap.
REQ-009 x,y SHALL be the position LEAD pixels after (hc,vc) in raster order:
- position index = (vc*H_TOTAL + hc + LEAD) mod (H_TOTAL*V_TOTAL)
- past line end: increments y and wraps x
- past frame end: wraps to y=0
REQ-010 x,y SHALL be raw counter values, including blanking positions; consumers qualify them with x < H_ACTIVE and y < V_ACTIVE.
REQ-011 line_start SHALL be 1 for exactly one output cycle per line, when hc=0.
REQ-012 frame_start SHALL be 1 for exactly one output cycle per frame, when hc=0 and vc=0.
REQ-013 frame_cnt SHALL increment by 1 on every vc wrap V_TOTAL-1 -> 0, wrapping 255 -> 0; the first frame after reset carries frame_cnt=0 alongside its frame_start.
REQ-014 With enable=0, the counters and x, y, blanking, h_sync, v_sync and frame_cnt SHALL hold, and line_start and frame_start SHALL be 0.
REQ-015 On return to enable=1, the sequence SHALL resume at the held position with no skipped or repeated position.
REQ-016 Dependency on LEAD SHALL be only as REQ-009; LEAD=0 makes x,y aligned with blanking.

Reset
REQ-017 rst=1 SHALL immediately, without a clk edge, force:
- hc=0, vc=0
- x=0, y=0
- blanking=1
- h_sync=!HS_POL, v_sync=!VS_POL
- line_start=0, frame_start=0
- frame_cnt=0
REQ-018 Reset SHALL be honoured mid-frame and regardless of enable.
REQ-019 The first enabled edge after rst deasserts SHALL output position (0,0).

Verification (default parameters: H_TOTAL=800, V_TOTAL=525)
REQ-020 Release rst, enable=1, first edge -> blanking=0, x=2, y=0, line_start=1, frame_start=1, frame_cnt=0, h_sync=1, v_sync=1.
REQ-021 Run one line -> blanking rises at output hc=640; h_sync=0 for exactly 96 cycles (hc 656..751); line_start period is 800 cycles.
REQ-022 Run full frames -> v_sync=0 for exactly 1600 cycles (vc 490..491); frame_start period is 420000 cycles; frame_cnt steps +1 per frame; with reduced V/H parameters, wraps 255 -> 0 after 256 frames.
REQ-023 Output position hc=798, vc=524 with LEAD=2 -> x=0, y=0; at hc=799, vc=0 -> x=1, y=1.
REQ-024 Drop enable for 10 cycles at hc=300 -> all outputs frozen and pulses 0; after re-enable, next output is hc=301, and total line length is 810 clocks.
REQ-025 Assert rst asynchronously mid-frame between edges -> outputs take REQ-017 values before the next edge; after release, REQ-020 repeats.
